sample_tx: RTL

SAMPLE_TX -- requirements
Module: sample_tx

---
 rtl/sample_pkg.sv | 16 +
 rtl/sample_tx_hold_timer.sv | 24 ++
 rtl/sample_tx.sv | 76 +++++++
 3 files changed

// File: rtl/sample_pkg.sv
// Shared types and widths for the sample line transmitter and its change-detecting receiver.
package sample_pkg;

    localparam int unsigned SAMPLE_W = 4;
    localparam int unsigned PHASE_W  = 3;

    typedef enum logic {
        IDLE,
        HOLD
    } tx_state_t;

    typedef enum logic [PHASE_W-1:0] {
        S0, S1, S2, S3, S4, S5, S6, S7
    } rx_state_t;

endpackage

// File: rtl/sample_tx_hold_timer.sv
// Down-counter that keeps the transmitter in HOLD; reports expiry when it reaches zero.
module hold_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 8'd1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sample_tx.sv
// Drives a toggle-tagged symbol onto sample and holds it long enough for the receiver to see it.
module sample_tx
    import sample_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sym_valid,
    input  logic [2:0]          sym_data,
    output logic                sym_ready,
    output logic [SAMPLE_W-1:0] sample,
    output logic [PHASE_W-1:0]  phase,
    output logic                wrap_pulse,
    output logic [7:0]          sent_count
);

    tx_state_t state, next_state;
    logic      transfer;
    logic      expired;

    assign transfer = sym_valid && sym_ready;

    hold_timer u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (transfer),
        .load_val (8'(HOLD_CYCLES - 1)),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        sym_ready  = 1'b0;
        case (state)
            IDLE: begin
                sym_ready = 1'b1;
                if (sym_valid) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (expired) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Toggle bit guarantees a visible change on sample even for repeated data.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample     <= '0;
            phase      <= '0;
            sent_count <= '0;
            wrap_pulse <= 1'b0;
        end else if (transfer) begin
            sample     <= {~sample[SAMPLE_W-1], sym_data};
            phase      <= phase + 3'd1;
            sent_count <= sent_count + 8'd1;
            wrap_pulse <= (rx_state_t'(phase) == S7);
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

endmodule
